// File: rtl/bp_fe_realigner_if.sv
// -----------------------------------------------------------------------------
// bp_fe_realigner_if
// Bundles the fetch-side and instruction-side handshakes of the front-end
// realigner. Signal names keep the realigner's own port direction suffixes so
// the mapping to the block is obvious.
//
//   redirect_i          flush all buffered state (PC redirect)
//   fetch_v_i           fetch word valid
//   fetch_pc_i          halfword-aligned PC of the first wanted parcel
//   fetch_data_i        little-endian word at {fetch_pc_i[vaddr-1:2],2'b00}
//   fetch_ready_o       word accepted when fetch_v_i & fetch_ready_o
//   instr_v_o           instruction valid
//   instr_pc_o          PC of instr_o
//   instr_o             full instruction, or {16'b0, parcel} when compressed
//   instr_compressed_o  instr_o[15:0] is an RVC parcel
//   instr_yumi_i        consumer takes instr_o (only while instr_v_o)
//
// Modports: master = fetch source / instruction consumer, slave = realigner.
// -----------------------------------------------------------------------------
interface bp_fe_realigner_if #(
    parameter int vaddr_width_p = 32'd39
);
    logic                     redirect_i;
    logic                     fetch_v_i;
    logic [vaddr_width_p-1:0] fetch_pc_i;
    logic [31:0]              fetch_data_i;
    logic                     fetch_ready_o;
    logic                     instr_v_o;
    logic [vaddr_width_p-1:0] instr_pc_o;
    logic [31:0]              instr_o;
    logic                     instr_compressed_o;
    logic                     instr_yumi_i;

    modport master (
        output redirect_i, fetch_v_i, fetch_pc_i, fetch_data_i, instr_yumi_i,
        input  fetch_ready_o, instr_v_o, instr_pc_o, instr_o, instr_compressed_o
    );

    modport slave (
        input  redirect_i, fetch_v_i, fetch_pc_i, fetch_data_i, instr_yumi_i,
        output fetch_ready_o, instr_v_o, instr_pc_o, instr_o, instr_compressed_o
    );
endinterface

// File: rtl/bp_fe_realigner.sv
// -----------------------------------------------------------------------------
// bp_fe_realigner
// Turns a stream of aligned 32-bit fetch words into a stream of instructions.
// With BP_FE_RVC_EN defined the block understands 16-bit RVC parcels: it walks
// each word one halfword at a time, emits compressed parcels as
// {16'b0, parcel}, and stitches 32-bit instructions that straddle two fetch
// words. Without BP_FE_RVC_EN every accepted word is emitted once, as a full
// instruction at its word-aligned PC.
//
// Ports:
//   clk_i    clock, all state updates on the rising edge
//   reset_i  synchronous active-high reset
//   fe_io    bp_fe_realigner_if.slave (fetch handshake, redirect, instr handshake)
//
// Configuration macro: BP_FE_RVC_EN (compressed-aware realignment).
// -----------------------------------------------------------------------------
typedef enum logic [1:0] {
    e_bp_inv_cfg     = 2'd0,
    e_bp_unicore_cfg = 2'd1
} bp_fe_realigner_cfg_e;

module bp_fe_realigner #(
    parameter bp_fe_realigner_cfg_e cfg_p = e_bp_inv_cfg
) (
    input  logic              clk_i,
    input  logic              reset_i,
    bp_fe_realigner_if.slave  fe_io
);
    // Every supported processor config uses Sv39 virtual addresses.
    function automatic int cfg_vaddr_width(input bp_fe_realigner_cfg_e cfg);
        case (cfg)
            e_bp_inv_cfg:     cfg_vaddr_width = 32'd39;
            e_bp_unicore_cfg: cfg_vaddr_width = 32'd39;
            default:          cfg_vaddr_width = 32'd39;
        endcase
    endfunction

    localparam int vaddr_width_p = cfg_vaddr_width(cfg_p);
    localparam int instr_width_p = 32'd32;
    localparam logic [vaddr_width_p-1:0] pc_two_lp = vaddr_width_p'(2);

    typedef enum logic [1:0] {
        e_empty    = 2'b00,
        e_word     = 2'b01
`ifdef BP_FE_RVC_EN
        ,e_straddle = 2'b10
`endif
    } state_e;

    state_e                    state_q, state_d;
    logic [instr_width_p-1:0]  buf_q, buf_d;
    logic [vaddr_width_p-1:0]  pc_q, pc_d;       // word-aligned PC of buf_q
    logic                      fetch_ready_s;
    logic                      accept_s;
    logic                      instr_v_s;
    logic [vaddr_width_p-1:0]  instr_pc_s;
    logic [instr_width_p-1:0]  instr_s;
    logic                      instr_comp_s;
    logic                      unused_pc_bits_s;

`ifdef BP_FE_RVC_EN
    logic                      ptr_q, ptr_d;     // 0: low halfword next, 1: high
    logic [15:0]               strad_parcel_q, strad_parcel_d;
    logic [vaddr_width_p-1:0]  strad_pc_q, strad_pc_d;
    logic                      strad_flag_q, strad_flag_d;
    logic                      low_rvc_s;
    logic                      high_rvc_s;

    assign low_rvc_s        = (buf_q[1:0]   != 2'b11);
    assign high_rvc_s       = (buf_q[17:16] != 2'b11);
    assign fetch_ready_s    = ~fe_io.redirect_i & ((state_q == e_empty) | (state_q == e_straddle));
    assign unused_pc_bits_s = fe_io.fetch_pc_i[0];
`else
    assign fetch_ready_s    = ~fe_io.redirect_i & (state_q == e_empty);
    assign unused_pc_bits_s = ^fe_io.fetch_pc_i[1:0];
`endif

    assign accept_s = fe_io.fetch_v_i & fetch_ready_s;

    // Output decode: purely a function of registered state.
    always_comb begin
        instr_v_s    = 1'b0;
        instr_pc_s   = pc_q;
        instr_s      = buf_q;
        instr_comp_s = 1'b0;
        if (state_q == e_word) begin
`ifdef BP_FE_RVC_EN
            if (strad_flag_q) begin
                // Second half of a straddling instruction is the low parcel.
                instr_v_s  = 1'b1;
                instr_pc_s = strad_pc_q;
                instr_s    = {buf_q[15:0], strad_parcel_q};
            end else if (!ptr_q) begin
                instr_v_s = 1'b1;
                if (low_rvc_s) begin
                    instr_s      = {16'h0000, buf_q[15:0]};
                    instr_comp_s = 1'b1;
                end else begin
                    instr_s      = buf_q;
                    instr_comp_s = 1'b0;
                end
            end else if (high_rvc_s) begin
                instr_v_s    = 1'b1;
                instr_pc_s   = pc_q + pc_two_lp;
                instr_s      = {16'h0000, buf_q[31:16]};
                instr_comp_s = 1'b1;
            end else begin
                // Upper parcel starts a 32-bit instruction: nothing to emit yet.
                instr_v_s = 1'b0;
            end
`else
            instr_v_s = 1'b1;
`endif
        end else begin
            instr_v_s = 1'b0;
        end
    end

    // Next-state logic: redirect beats acceptance and yumi.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        pc_d    = pc_q;
`ifdef BP_FE_RVC_EN
        ptr_d          = ptr_q;
        strad_parcel_d = strad_parcel_q;
        strad_pc_d     = strad_pc_q;
        strad_flag_d   = strad_flag_q;
`endif
        if (fe_io.redirect_i) begin
            state_d = e_empty;
`ifdef BP_FE_RVC_EN
            strad_flag_d = 1'b0;
`endif
        end else if (accept_s) begin
            state_d = e_word;
            buf_d   = fe_io.fetch_data_i;
            pc_d    = {fe_io.fetch_pc_i[vaddr_width_p-1:2], 2'b00};
`ifdef BP_FE_RVC_EN
            ptr_d = fe_io.fetch_pc_i[1];
            // Only the word directly following the saved parcel completes it.
            strad_flag_d = (state_q == e_straddle)
                         & (fe_io.fetch_pc_i == (strad_pc_q + pc_two_lp));
`endif
        end else if (state_q == e_word) begin
`ifdef BP_FE_RVC_EN
            if (strad_flag_q) begin
                if (fe_io.instr_yumi_i) begin
                    strad_flag_d = 1'b0;
                    ptr_d        = 1'b1;
                end else begin
                    strad_flag_d = 1'b1;
                end
            end else if (!ptr_q) begin
                if (fe_io.instr_yumi_i) begin
                    if (low_rvc_s) begin
                        ptr_d = 1'b1;
                    end else begin
                        state_d = e_empty;
                    end
                end else begin
                    ptr_d = 1'b0;
                end
            end else if (high_rvc_s) begin
                if (fe_io.instr_yumi_i) begin
                    state_d = e_empty;
                end else begin
                    state_d = e_word;
                end
            end else begin
                // Park the first half and go fetch the next word.
                strad_parcel_d = buf_q[31:16];
                strad_pc_d     = pc_q + pc_two_lp;
                state_d        = e_straddle;
            end
`else
            if (fe_io.instr_yumi_i) begin
                state_d = e_empty;
            end else begin
                state_d = e_word;
            end
`endif
        end else begin
            state_d = state_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_empty;
            buf_q   <= '0;
            pc_q    <= '0;
`ifdef BP_FE_RVC_EN
            ptr_q          <= 1'b0;
            strad_parcel_q <= 16'h0000;
            strad_pc_q     <= '0;
            strad_flag_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            pc_q    <= pc_d;
`ifdef BP_FE_RVC_EN
            ptr_q          <= ptr_d;
            strad_parcel_q <= strad_parcel_d;
            strad_pc_q     <= strad_pc_d;
            strad_flag_q   <= strad_flag_d;
`endif
        end
    end

    assign fe_io.fetch_ready_o      = fetch_ready_s;
    assign fe_io.instr_v_o          = instr_v_s;
    assign fe_io.instr_pc_o         = instr_pc_s;
    assign fe_io.instr_o            = instr_s;
    assign fe_io.instr_compressed_o = instr_comp_s;
endmodule

// File: doc/bp_fe_realigner.md
BP_FE_REALIGNER -- requirements
Module: bp_fe_realigner

Interface
REQ-001 SHALL have parameter cfg_p, default e_bp_inv_cfg; selects the processor config, which supplies vaddr_width_p and instr_width_p (32).
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port redirect_i  input  1  flush all buffered state (PC redirect).
REQ-005 SHALL have port fetch_v_i  input  1  fetch word valid.
REQ-006 SHALL have port fetch_pc_i  input  vaddr_width_p  halfword-aligned PC of the first wanted parcel.
REQ-007 SHALL have port fetch_data_i  input  32  word at {fetch_pc_i[vaddr-1:2],2'b00}, little-endian.
REQ-008 SHALL have port fetch_ready_o  output  1  word accepted when fetch_v_i & fetch_ready_o.
REQ-009 SHALL have port instr_v_o  output  1  instruction valid.
REQ-010 SHALL have port instr_pc_o  output  vaddr_width_p  PC of instr_o.
REQ-011 SHALL have port instr_o  output  32  full instruction, or {16'b0, parcel} when compressed.
REQ-012 SHALL have port instr_compressed_o  output  1  instr_o[15:0] is an RVC parcel for the downstream expander.
REQ-013 SHALL have port instr_yumi_i  input  1  consumer takes instr_o; legal only while instr_v_o.

Function
REQ-014 SHALL hold one 32-bit word buffer, a halfword pointer ptr, a 16-bit straddle parcel, its PC, and a straddle flag; state in {e_empty, e_word, e_straddle}.
REQ-015 SHALL drive fetch_ready_o = ~redirect_i & (state==e_empty | state==e_straddle).
REQ-016 On acceptance: SHALL load the buffer, set ptr=fetch_pc_i[1], move to e_word; instr_v_o rises the next cycle (latency 1).
REQ-017 In e_word with ptr=0: low parcel bits[1:0]!=2'b11 -> emit compressed parcel, PC=word PC; on yumi ptr=1.
REQ-018 In e_word with ptr=0 and bits[1:0]==2'b11 -> emit full word, compressed=0; on yumi go to e_empty.
REQ-019 In e_word with ptr=1 and upper parcel compressed -> emit it, PC=word PC+2; on yumi go to e_empty.
REQ-020 In e_word with ptr=1 and upper parcel bits[17:16]==2'b11 -> instr_v_o=0; save parcel and PC+2 to straddle regs; go to e_straddle the next cycle without waiting for yumi.
REQ-021 Word accepted in e_straddle with fetch_pc_i==straddle PC+2 SHALL set the straddle flag; in e_word the first output is then {word[15:0], straddle parcel}, PC=straddle PC, compressed=0; on yumi flag clears and ptr=1.
REQ-022 Word accepted in e_straddle with any other PC SHALL discard the straddle parcel and be treated as a fresh word per REQ-016.
REQ-023 instr_v_o, instr_pc_o, instr_o, instr_compressed_o SHALL be functions of registered state only and SHALL stay stable while instr_v_o & ~instr_yumi_i.
REQ-024 redirect_i SHALL take priority over yumi and acceptance: next cycle state=e_empty, flag cleared, instr_v_o=0.
REQ-025 PC arithmetic SHALL be modulo 2^vaddr_width_p; straddle across the top of the address space wraps to 0.

Reset
REQ-026 reset_i SHALL force state=e_empty, ptr=0, straddle flag=0, instr_v_o=0; buffered data and PCs are don't-care.
REQ-027 reset_i SHALL override redirect_i, yumi and acceptance in the same cycle; fetch_ready_o=1 the cycle after reset deasserts.

Configuration
REQ-028 Macro BP_FE_RVC_EN defined SHALL give the compressed-aware behaviour of REQ-016..REQ-022.
REQ-029 Without BP_FE_RVC_EN: each accepted word is emitted once as a full instruction at {fetch_pc_i[vaddr-1:2],2'b00}; ptr, straddle and e_straddle are absent; instr_compressed_o tied 0.

Verification
REQ-030 Accept 0x00a00513 @0x80000000 -> next cycle instr_v_o=1, instr_o=0x00a00513, pc 0x80000000, compressed=0.
REQ-031 Accept 0x45014581 @0x80000000 -> outputs 0x00004581 @0x80000000 and then 0x00004501 @0x80000002, both compressed, with yumi held high.
REQ-032 Accept 0x05134581 @0x80000000, then 0x000000a0 @0x80000004 -> outputs 0x4581 @0x80000000 and then 0x00a00513 @0x80000002; afterwards ptr=1 and upper parcel 0x0000 is emitted as compressed @0x80000006.
REQ-033 Accept 0x4501ffff @0x80000002 -> single compressed 0x4501 @0x80000002, then fetch_ready_o=1.
REQ-034 Enter e_straddle, assert redirect_i, then accept 0x00a00513 @0x80000100 -> straddle parcel dropped; output 0x00a00513 @0x80000100.
REQ-035 Hold instr_yumi_i=0 for 5 cycles with a valid output -> all outputs unchanged and fetch_ready_o=0 throughout.
